// File: rtl/mem_pkg.sv
// Shared memory-system definitions: widths, cache controller state and
// coherency encodings (the latter reserved for memory_subsystem).
package mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MEM_RD,
    MEM_WR,
    RESP
  } cache_state_t;

  typedef enum logic [1:0] {
    I,
    M,
    S
  } coherency_t;

endpackage

// File: rtl/l1_tag_data_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, one write port
// that always marks the line valid, and a tag-qualified clear-valid port.
module l1_tag_data_array #(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 8,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic [TAG_W-1:0]  clr_tag
);

  logic              valid_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];
  logic              clr_hit;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // A same-edge write decides the tag the invalidate is matched against,
  // so an invalidate of the address being filled or written still lands.
  always_comb begin
    clr_hit = 1'b0;
    if (clr_en) begin
      if (wr_en && (wr_idx == clr_idx)) clr_hit = (wr_tag == clr_tag);
      else                              clr_hit = valid_q[clr_idx] && (tag_q[clr_idx] == clr_tag);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
    end else begin
      if (wr_en)   valid_q[wr_idx]  <= 1'b1;
      if (clr_hit) valid_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate L1 controller for one core.
// Optional hit/miss counters are built when L1_CACHE_STATS_EN is defined.
module l1_cache_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_SIZE = 2,
  parameter int NUM_LINES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req_valid,
  input  logic                   cpu_req_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_SIZE*8-1:0] cpu_wdata,
  output logic                   cpu_req_ready,
  output logic                   cpu_resp_valid,
  output logic [DATA_SIZE*8-1:0] cpu_rdata,
  output logic                   mem_req,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_SIZE*8-1:0] mem_wdata,
  input  logic                   mem_resp,
  input  logic [DATA_SIZE*8-1:0] mem_rdata,
  input  logic                   inv_valid,
  input  logic [ADDR_W-1:0]      inv_addr,
`ifdef L1_CACHE_STATS_EN
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count,
`endif
  output cache_state_t           state_dbg
);

  localparam int DW    = DATA_SIZE * 8;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  // Handshake: a request transfers on a clk edge where cpu_req_valid and
  // cpu_req_ready are both 1; cpu_resp_valid then pulses once per request.
  cache_state_t      state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0]     req_wdata_q, req_wdata_d;
  logic              ready_d, resp_d, mem_req_d, mem_rd_d, mem_wr_d;
  logic [DW-1:0]     rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic              rd_valid, wr_en, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [DW-1:0]     rd_data, wr_data;
  logic              hit_inc, miss_inc;

  assign state_dbg = state_q;
  assign hit = rd_valid && (rd_tag == req_addr_q[ADDR_W-1:IDX_W]);

  l1_tag_data_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .DATA_W    (DW)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (req_addr_q[IDX_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (req_addr_q[IDX_W-1:0]),
    .wr_tag   (req_addr_q[ADDR_W-1:IDX_W]),
    .wr_data  (wr_data),
    .clr_en   (inv_valid),
    .clr_idx  (inv_addr[IDX_W-1:0]),
    .clr_tag  (inv_addr[ADDR_W-1:IDX_W])
  );

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    ready_d     = cpu_req_ready;
    resp_d      = 1'b0;
    rdata_d     = cpu_rdata;
    mem_req_d   = mem_req;
    mem_rd_d    = mem_rd;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wr_en       = 1'b0;
    wr_data     = req_wdata_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cpu_req_valid) begin
          ready_d     = 1'b0;
          req_we_d    = cpu_req_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (!req_we_q) begin
          if (hit) begin
            hit_inc = 1'b1;
            rdata_d = rd_data;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            miss_inc   = 1'b1;
            mem_req_d  = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = req_addr_q;
            state_d    = MEM_RD;
          end
        end else begin
          wr_en       = hit;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = req_addr_q;
          mem_wdata_d = req_wdata_q;
          state_d     = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mem_resp) begin
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          mem_rd_d  = 1'b0;
          resp_d    = 1'b1;
          state_d   = RESP;
        end
      end
      MEM_WR: begin
        if (mem_resp) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          resp_d    = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_req        <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      state_q        <= state_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      cpu_req_ready  <= ready_d;
      cpu_resp_valid <= resp_d;
      cpu_rdata      <= rdata_d;
      mem_req        <= mem_req_d;
      mem_rd         <= mem_rd_d;
      mem_wr         <= mem_wr_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
    end
  end

`ifdef L1_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != 16'hFFFF))   hit_count  <= hit_count + 16'd1;
      if (miss_inc && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule
